// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants for the CDB arbitration slice (the parameters.v set) and
//   the FU-index-to-tag map.
//   Tag 0 is reserved as READY: the register holds a committed value and no
//   FU is producing it. FU i therefore broadcasts under tag i+1.
package cdb_arbiter_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int REG_INDEX     = 5;
  localparam int FU_INDEX      = 3;
  localparam int REG_FILE_SIZE = 32;

  localparam logic [FU_INDEX-1:0] READY = '0;

  // Tag carried on the CDB by functional unit fu_idx.
  function automatic int unsigned fu_tag(input int unsigned fu_idx);
    return fu_idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Picks one requester per cycle. Purely combinational.
//   Default build: round-robin search that starts at ptr and wraps; next_ptr
//   is the slot just after the winner (held at ptr when nobody requests).
//   CDB_FIXED_PRIO_EN defined: static priority, lowest index wins; ptr is
//   ignored and next_ptr is tied to zero.
// Ports
//   req       in   NUM_FU  request vector
//   ptr       in   PTR_W   round-robin start position
//   grant     out  NUM_FU  one-hot (or zero) grant
//   next_ptr  out  PTR_W   pointer value to load if a grant is taken
module rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [PTR_W-1:0]  next_ptr
);

`ifdef CDB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    grant    = '0;
    next_ptr = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  // Two passes: first the slots at or above ptr, then the slots below it.
  // Together they scan ptr, ptr+1, ..., NUM_FU-1, 0, ..., ptr-1.
  always_comb begin
    logic found;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        next_ptr = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        next_ptr = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Arbitrates the common data bus among NUM_FU finished functional units,
//   broadcasts the winner's tag/value one cycle later, and retires the value
//   into the register file and reg_status when the register still names
//   this tag as its producer.
//   Build option: CDB_FIXED_PRIO_EN selects static lowest-index priority
//   instead of round-robin (the rr pointer disappears).
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   fu_req/fu_data/fu_dest      per-FU finished result (packed slices)
//   fu_grant                    one-hot combinational grant
//   cdb_valid/cdb_tag/cdb_data  registered broadcast
//   rs_query_num/status         reg_status read port for the CDB dest
//   issue_rs_enable/src         issue stage renaming a register this cycle
//   write_reg_*                 register file write port
//   write_rs_*                  reg_status write port (status always READY)
// Handshake
//   fu_req is the valid and fu_grant is the ready. A result transfers at a
//   posedge where both are high. Once fu_req rises, req/data/dest stay stable
//   until that transfer; dropping fu_req without a grant is illegal.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int WORD_SIZE = cdb_arbiter_pkg::WORD_SIZE,
  parameter int REG_INDEX = cdb_arbiter_pkg::REG_INDEX,
  parameter int FU_INDEX  = cdb_arbiter_pkg::FU_INDEX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_FU-1:0]           fu_req,
  input  logic [NUM_FU*WORD_SIZE-1:0] fu_data,
  input  logic [NUM_FU*REG_INDEX-1:0] fu_dest,
  output logic [NUM_FU-1:0]           fu_grant,
  output logic                        cdb_valid,
  output logic [FU_INDEX-1:0]         cdb_tag,
  output logic [WORD_SIZE-1:0]        cdb_data,
  output logic [REG_INDEX-1:0]        rs_query_num,
  input  logic [FU_INDEX-1:0]         rs_query_status,
  input  logic                        issue_rs_enable,
  input  logic [REG_INDEX-1:0]        issue_rs_src,
  output logic [REG_INDEX-1:0]        write_reg_src,
  output logic [WORD_SIZE-1:0]        write_reg_data,
  output logic                        write_reg_enable,
  output logic [REG_INDEX-1:0]        write_rs_src,
  output logic [FU_INDEX-1:0]         write_rs_status,
  output logic                        write_rs_enable
);
  import cdb_arbiter_pkg::*;

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [FU_INDEX-1:0] TAG_READY = FU_INDEX'(READY);

  logic [NUM_FU-1:0]    grant_raw;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_next;
  logic                 any_grant;
  logic [WORD_SIZE-1:0] sel_data;
  logic [REG_INDEX-1:0] sel_dest;
  logic [FU_INDEX-1:0]  sel_tag;
  logic [REG_INDEX-1:0] cdb_dest;
  logic                 tag_match;
  logic                 issue_clash;

  rr_arbiter #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req      (fu_req),
    .ptr      (rr_ptr),
    .grant    (grant_raw),
    .next_ptr (rr_next)
  );

  // No grant may escape while reset is held, even with requests pending.
  assign fu_grant  = reset ? '0 : grant_raw;
  assign any_grant = |fu_grant;

`ifdef CDB_FIXED_PRIO_EN
  logic [PTR_W-1:0] unused_rr_next;
  assign unused_rr_next = rr_next;
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next;
    end
  end
`endif

  // Winner's payload; the grant is one-hot so at most one branch fires.
  always_comb begin
    sel_data = '0;
    sel_dest = '0;
    sel_tag  = TAG_READY;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_grant[i]) begin
        sel_data = fu_data[i*WORD_SIZE +: WORD_SIZE];
        sel_dest = fu_dest[i*REG_INDEX +: REG_INDEX];
        sel_tag  = FU_INDEX'(fu_tag(i));
      end
    end
  end

  // One-deep CDB stage, refilled every cycle that has a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= TAG_READY;
      cdb_data  <= '0;
      cdb_dest  <= '0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
        cdb_dest <= sel_dest;
      end
    end
  end

  assign rs_query_num = cdb_dest;

  // A tag mismatch means the register was renamed after this result was
  // issued; the broadcast still feeds the reservation stations but the
  // architectural state must not be touched. An entry caught by reset is
  // dropped outright.
  assign tag_match   = cdb_valid && !reset && (rs_query_status == cdb_tag);
  // Issue renaming the same register this cycle owns reg_status.
  assign issue_clash = issue_rs_enable && (issue_rs_src == cdb_dest);

  assign write_reg_src    = cdb_dest;
  assign write_reg_data   = cdb_data;
  assign write_reg_enable = tag_match;
  assign write_rs_src     = cdb_dest;
  assign write_rs_status  = TAG_READY;
  assign write_rs_enable  = tag_match && !issue_clash;

  // Requesters must hold their request until it is granted.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_req_hold
    a_req_hold : assert property (@(posedge clk) disable iff (reset)
      (fu_req[g] && !fu_grant[g]) |=> fu_req[g]);
  end

  a_grant_onehot : assert property (@(posedge clk)
    $onehot0(fu_grant) && ((fu_grant & ~fu_req) == '0));

endmodule
